// File: rtl/sha256_block_fetch_pkg.sv
// sha256_pkg
// Shared types, constants and helpers for the SHA-256 block fetcher.
//   state_t          : fetcher FSM states
//   PAD_WORD         : the lone 0x80 marker word
//   WORDS_PER_BLOCK  : 32-bit words in one 512-bit block
//   calc_num_blocks  : blocks needed for a message of a given byte length
//   mask_data        : keep the leading message bytes of a word, append 0x80
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    SEND,
    DONE
  } state_t;

  localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
  localparam int          WORDS_PER_BLOCK = 16;

  // One block per 64 bytes, plus one more when the 0x80 marker and the
  // 8-byte length still fit after the tail, otherwise two more.
  function automatic logic [10:0] calc_num_blocks(input logic [15:0] size);
    return {1'b0, size[15:6]} + ((size[5:0] < 6'd56) ? 11'd1 : 11'd2);
  endfunction

  // Bytes are big-endian inside a word, so the message bytes that are kept
  // sit in the high end and the marker follows directly below them.
  function automatic logic [31:0] mask_data(input logic [31:0] data,
                                            input logic [1:0]  keep);
    logic [31:0] word;
    case (keep)
      2'd1:    word = {data[31:24], 8'h80, 16'h0000};
      2'd2:    word = {data[31:16], 8'h80, 8'h00};
      2'd3:    word = {data[31:8], 8'h80};
      default: word = PAD_WORD;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word
// Combinational word selector: decides what the padded stream holds at
// global word g of a message of s bytes.
//   g             in  16 : global word index within the padded stream
//   s             in  16 : message length in bytes
//   mem_read_data in  32 : memory word for index g (only used when needed)
//   last_block    in   1 : word g lies in the final block
//   word_idx      in   4 : index of word g inside its block
//   pad_word      out 32 : padded word value
//   needs_mem     out  1 : the word carries message bytes and must be read
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [15:0] g,
  input  logic [15:0] s,
  input  logic [31:0] mem_read_data,
  input  logic        last_block,
  input  logic [3:0]  word_idx,
  output logic [31:0] pad_word,
  output logic        needs_mem
);

  // Byte positions are kept at 18 bits so 4*g never wraps.
  logic [17:0] p;
  logic [17:0] p_end;
  logic [17:0] s_ext;

  assign p     = {g, 2'b00};
  assign p_end = p + 18'd4;
  assign s_ext = {2'b00, s};

  // The length words only ever land beyond the marker, so the position
  // tests can be evaluated first without hiding them.
  always_comb begin
    pad_word  = 32'h0000_0000;
    needs_mem = 1'b0;
    if (p_end <= s_ext) begin
      pad_word  = mem_read_data;
      needs_mem = 1'b1;
    end else if (p < s_ext) begin
      pad_word  = mask_data(mem_read_data, s[1:0]);
      needs_mem = 1'b1;
    end else if (p == s_ext) begin
      pad_word = PAD_WORD;
    end else if (last_block && (word_idx == 4'd15)) begin
      pad_word = {13'd0, s, 3'b000};
    end
  end

endmodule

// File: rtl/sha256_block_fetch.sv
// sha256_block_fetch
// Reads a byte message from word memory, applies SHA-256 padding and streams
// it as 16-word blocks to the compressor.
//   clk, reset     : clock, asynchronous active-high reset
//   start          : begin a message (sampled in IDLE only)
//   message_addr   : word address of message byte 0
//   msg_size       : message length in bytes
//   mem_addr       : registered memory read address
//   mem_read_data  : memory data, valid the cycle after mem_addr
//   word_valid/word_ready/word_data : padded word stream
//   word_idx       : word index inside its block
//   block_last     : current word belongs to the final block
//   num_blocks     : block count of the captured message
//   busy, done     : message in progress, one-cycle completion pulse
module sha256_block_fetch
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] msg_size,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [3:0]  word_idx,
  output logic        block_last,
  output logic [10:0] num_blocks,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] MAX_SIZE = 16'(MAX_BYTES);

  state_t      state;
  logic [15:0] addr_q;
  logic [15:0] size_q;
  logic [15:0] g;
  logic [10:0] b;

  logic [15:0] size_in;
  logic [10:0] blocks_in;
  logic [10:0] b_next;
  logic        last_word;
  logic        xfer;

  logic [15:0] sel_g;
  logic [15:0] sel_s;
  logic [3:0]  sel_idx;
  logic        sel_last;
  logic [31:0] pad_word;
  logic        needs_mem;

  // Oversized requests are clamped so the counters can never overrun.
  assign size_in   = (msg_size > MAX_SIZE) ? MAX_SIZE : msg_size;
  assign blocks_in = calc_num_blocks(size_in);
  assign b_next    = (word_idx == 4'd15) ? b + 11'd1 : b;
  assign last_word = (b == num_blocks - 11'd1) &&
                     (word_idx == 4'(WORDS_PER_BLOCK - 1));
  assign xfer      = (state == SEND) && word_valid && word_ready;

  // The word selector looks at the word about to be entered: word 0 of the
  // incoming message in IDLE, the following word in SEND, and the current
  // word while its memory read is in flight.
  always_comb begin
    sel_g    = g;
    sel_s    = size_q;
    sel_idx  = word_idx;
    sel_last = (b == num_blocks - 11'd1);
    case (state)
      IDLE: begin
        sel_g    = 16'd0;
        sel_s    = size_in;
        sel_idx  = 4'd0;
        sel_last = (blocks_in == 11'd1);
      end
      SEND: begin
        sel_g    = g + 16'd1;
        sel_idx  = word_idx + 4'd1;
        sel_last = (b_next == num_blocks - 11'd1);
      end
      default: ;
    endcase
  end

  sha256_pad_word u_pad_word (
    .g             (sel_g),
    .s             (sel_s),
    .mem_read_data (mem_read_data),
    .last_block    (sel_last),
    .word_idx      (sel_idx),
    .pad_word      (pad_word),
    .needs_mem     (needs_mem)
  );

  // Main FSM. Pad words are loaded straight into word_data and keep
  // word_valid high; message words go through REQ/CAPT for the memory read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      g          <= '0;
      b          <= '0;
      mem_addr   <= '0;
      word_data  <= '0;
      word_idx   <= '0;
      num_blocks <= '0;
      word_valid <= 1'b0;
      block_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr_q     <= message_addr;
            size_q     <= size_in;
            g          <= '0;
            b          <= '0;
            word_idx   <= '0;
            num_blocks <= blocks_in;
            block_last <= sel_last;
            busy       <= 1'b1;
            if (needs_mem) begin
              mem_addr <= message_addr;
              state    <= REQ;
            end else begin
              word_data  <= pad_word;
              word_valid <= 1'b1;
              state      <= SEND;
            end
          end
        end
        REQ: begin
          state <= CAPT;
        end
        CAPT: begin
          word_data  <= pad_word;
          word_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (xfer) begin
            g        <= g + 16'd1;
            word_idx <= word_idx + 4'd1;
            b        <= b_next;
            if (last_word) begin
              word_valid <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              block_last <= sel_last;
              if (needs_mem) begin
                word_valid <= 1'b0;
                mem_addr   <= addr_q + g + 16'd1;
                state      <= REQ;
              end else begin
                word_data <= pad_word;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_fetch.sv
// tb_sha256_block_fetch
// Scoreboard bench for sha256_block_fetch: a byte-level padding model
// queues the expected words, a monitor pops and compares on each transfer.
module tb_sha256_block_fetch;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] message_addr;
  logic [15:0] msg_size;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [3:0]  word_idx;
  logic        block_last;
  logic [10:0] num_blocks;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:65535];
  exp_t        exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int xfer_count   = 0;
  int done_count   = 0;
  int cur_nb       = 0;

  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;
  logic [15:0] prev_addr;

  sha256_block_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .message_addr  (message_addr),
    .msg_size      (msg_size),
    .mem_addr      (mem_addr),
    .mem_read_data (mem_read_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .word_data     (word_data),
    .word_idx      (word_idx),
    .block_last    (block_last),
    .num_blocks    (num_blocks),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read word memory: data follows the address by one cycle.
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] msgByte(input logic [15:0] base, input int i);
    logic [15:0] a;
    logic [31:0] w;
    a = base + 16'(i / 4);
    w = mem[a];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  // Transfer monitor: scoreboard pop plus stability checks on held words.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall valid", 32'(word_valid), 32'd1);
        checkOutput("stall data", word_data, prev_data);
        checkOutput("stall idx", 32'(word_idx), 32'(prev_idx));
        checkOutput("stall addr", 32'(mem_addr), 32'(prev_addr));
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("w%0d data", xfer_count), word_data, e.data);
          checkOutput($sformatf("w%0d idx", xfer_count), 32'(word_idx), 32'(e.idx));
          checkOutput($sformatf("w%0d last", xfer_count), 32'(block_last), 32'(e.last));
        end
        xfer_count++;
      end
      stall_prev = word_valid && !word_ready;
      prev_data  = word_data;
      prev_idx   = word_idx;
      prev_addr  = mem_addr;
      if (done) done_count++;
    end
  end

  // Builds the expected padded stream byte by byte, then starts the DUT
  // and checks the start-up latency.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] size);
    int          total;
    logic [63:0] bitlen;
    logic [7:0]  by;
    logic [31:0] w;
    exp_t        e;
    cur_nb = ((int'(size) + 8) / 64) + 1;
    total  = cur_nb * 64;
    bitlen = 64'(size) * 64'd8;
    for (int wi = 0; wi < cur_nb * 16; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = wi * 4 + k;
        if (i < int'(size))       by = msgByte(addr, i);
        else if (i == int'(size)) by = 8'h80;
        else if (i >= total - 8)  by = bitlen[8 * (total - 1 - i) +: 8];
        else                      by = 8'h00;
        w = {w[23:0], by};
      end
      e.data = w;
      e.idx  = 4'(wi % 16);
      e.last = (wi / 16) == (cur_nb - 1);
      exp_q.push_back(e);
    end
    xfer_count = 0;
    done_count = 0;
    @(negedge clk);
    message_addr = addr;
    msg_size     = size;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after start", 32'(busy), 32'd1);
    checkOutput("num_blocks", 32'(num_blocks), 32'(cur_nb));
    if (size != 16'd0) begin
      checkOutput("req mem_addr", 32'(mem_addr), 32'(addr));
      checkOutput("req valid low", 32'(word_valid), 32'd0);
      @(negedge clk);
      checkOutput("capt valid low", 32'(word_valid), 32'd0);
      @(negedge clk);
      checkOutput("first valid", 32'(word_valid), 32'd1);
    end else begin
      checkOutput("pad first valid", 32'(word_valid), 32'd1);
    end
  endtask

  task automatic finishMessage();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done seen", 32'(seen), 32'd1);
    checkOutput("busy in done", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("busy cleared", 32'(busy), 32'd0);
    checkOutput("done one cycle", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("done count", 32'(done_count), 32'd1);
    checkOutput("words left", 32'(exp_q.size()), 32'd0);
    checkOutput("transfers", 32'(xfer_count), 32'(cur_nb * 16));
  endtask

  task automatic runMessage(input logic [15:0] addr, input logic [15:0] size);
    applyStimulus(addr, size);
    finishMessage();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, " word_data"}, word_data, 32'd0);
    checkOutput({tag, " word_idx"}, 32'(word_idx), 32'd0);
    checkOutput({tag, " num_blocks"}, 32'(num_blocks), 32'd0);
    checkOutput({tag, " word_valid"}, 32'(word_valid), 32'd0);
    checkOutput({tag, " block_last"}, 32'(block_last), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        ok;
    logic [15:0] a;
    reset        = 1'b1;
    start        = 1'b0;
    word_ready   = 1'b1;
    message_addr = '0;
    msg_size     = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] 80-byte message, words hold their index");
    for (int i = 0; i < 20; i++) mem[16'h0100 + 16'(i)] = 32'(i);
    runMessage(16'h0100, 16'd80);

    $display("[TB] 3-byte message");
    mem[16'h0200] = 32'hAABB_CCDD;
    runMessage(16'h0200, 16'd3);

    $display("[TB] 56-byte message");
    for (int i = 0; i < 14; i++) mem[16'h0300 + 16'(i)] = $urandom;
    runMessage(16'h0300, 16'd56);

    $display("[TB] empty message");
    runMessage(16'h0400, 16'd0);

    $display("[TB] 55- and 61-byte messages");
    for (int i = 0; i < 14; i++) mem[16'h0500 + 16'(i)] = $urandom;
    runMessage(16'h0500, 16'd55);
    for (int i = 0; i < 16; i++) mem[16'h0600 + 16'(i)] = $urandom;
    runMessage(16'h0600, 16'd61);

    $display("[TB] backpressure on word 2, address wrap");
    for (int i = 0; i < 5; i++) begin
      a = 16'hFFFE + 16'(i);
      mem[a] = $urandom;
    end
    applyStimulus(16'hFFFE, 16'd20);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (xfer_count == 2) ok = 1'b1;
    end
    checkOutput("reach word 2", 32'(ok), 32'd1);
    word_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (word_valid) ok = 1'b1;
    end
    checkOutput("word 2 valid", 32'(ok), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bp held data", word_data, exp_q[0].data);
    checkOutput("bp held idx", 32'(word_idx), 32'd2);
    word_ready = 1'b1;
    finishMessage();

    $display("[TB] reset at block 1 word 5, then restart");
    applyStimulus(16'h0100, 16'd80);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      if (xfer_count == 21) ok = 1'b1;
    end
    checkOutput("reach b1w5", 32'(ok), 32'd1);
    checkOutput("b1w5 idx", 32'(word_idx), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    done_count = 0;
    repeat (5) @(negedge clk);
    checkOutput("no done after reset", 32'(done_count), 32'd0);
    runMessage(16'h0100, 16'd80);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
